// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types for the hazard/forwarding controller: forwarding selects,
// the shadow destination-tag entry and the hazard FSM encoding.
package hazard_forward_ctrl_pkg;

    localparam int PKG_REG_AW = 5;

    localparam logic [1:0] FWD_ID  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef struct packed {
        logic                  rf_en;
        logic                  load;
        logic [PKG_REG_AW-1:0] dest;
    } shadow_entry_t;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_STALL = 1'b1
    } hz_state_e;

    // Register 0 is hardwired to zero, so it never produces a match.
    function automatic logic src_match(shadow_entry_t e, logic [PKG_REG_AW-1:0] s);
        return e.rf_en && (e.dest == s) && (s != '0);
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_port_sel.sv
// Priority match of one ID source operand against the EX/MEM/WB shadow tags;
// the youngest producer wins.
module fwd_port_sel
    import hazard_forward_ctrl_pkg::*;
(
    input  logic [PKG_REG_AW-1:0] src_i,
    input  logic                  used_i,
    input  shadow_entry_t         ex_i,
    input  shadow_entry_t         mem_i,
    input  shadow_entry_t         wb_i,
    output logic [1:0]            sel_o,
    output logic                  ex_match_o
);

    always_comb begin
        sel_o      = FWD_ID;
        ex_match_o = 1'b0;
        if (used_i) begin
            if (src_match(ex_i, src_i)) begin
                sel_o      = FWD_EX;
                ex_match_o = 1'b1;
            end else if (src_match(mem_i, src_i)) begin
                sel_o = FWD_MEM;
            end else if (src_match(wb_i, src_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage core: shadows the destination
// tags of EX/MEM/WB, drives ID-stage forwarding selects and load-use stalls.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int REG_AW      = PKG_REG_AW,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [REG_AW-1:0]      id_rs,
    input  logic [REG_AW-1:0]      id_rt,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic [REG_AW-1:0]      id_dest,
    input  logic                   id_rf_enable,
    input  logic                   id_load_instr,
    input  logic                   pipe_hold,
    output logic [1:0]             fwd_sel_a,
    output logic [1:0]             fwd_sel_b,
    output logic                   nop_insert,
    output logic                   pc_ld,
    output logic                   ifid_ld,
    output logic                   hz_state,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // Handshake: pc_ld/ifid_ld are load enables valid every cycle; when both are
    // low the front end must re-present the same ID instruction next cycle.

    shadow_entry_t             ex_q, mem_q, wb_q;
    shadow_entry_t             id_entry;
    hz_state_e                 state_q, state_d;
    logic [STALL_CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [1:0]                sel_a, sel_b;
    logic                      ex_match_a, ex_match_b;
    logic                      luh;

    assign id_entry.rf_en = id_rf_enable;
    assign id_entry.load  = id_load_instr;
    assign id_entry.dest  = id_dest;

    fwd_port_sel u_sel_rs (
        .src_i      (id_rs),
        .used_i     (id_uses_rs),
        .ex_i       (ex_q),
        .mem_i      (mem_q),
        .wb_i       (wb_q),
        .sel_o      (sel_a),
        .ex_match_o (ex_match_a)
    );

    fwd_port_sel u_sel_rt (
        .src_i      (id_rt),
        .used_i     (id_uses_rt),
        .ex_i       (ex_q),
        .mem_i      (mem_q),
        .wb_i       (wb_q),
        .sel_o      (sel_b),
        .ex_match_o (ex_match_b)
    );

    assign luh = ex_q.load & ex_q.rf_en & (ex_match_a | ex_match_b);

    // Outputs are forced to their idle values while reset is asserted so the
    // front end sees a clean pipeline without waiting for a clock edge.
    always_comb begin
        fwd_sel_a   = sel_a;
        fwd_sel_b   = sel_b;
        nop_insert  = 1'b0;
        pc_ld       = 1'b1;
        ifid_ld     = 1'b1;
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        if (!reset_n) begin
            fwd_sel_a = FWD_ID;
            fwd_sel_b = FWD_ID;
        end else if (pipe_hold) begin
            pc_ld   = 1'b0;
            ifid_ld = 1'b0;
        end else begin
            if (luh) begin
                nop_insert = 1'b1;
                pc_ld      = 1'b0;
                ifid_ld    = 1'b0;
            end
            case (state_q)
                HZ_RUN: begin
                    if (luh) begin
                        state_d = HZ_STALL;
                        if (stall_cnt_q != {STALL_CNT_W{1'b1}})
                            stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end
                HZ_STALL: state_d = HZ_RUN;
                default:  state_d = HZ_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            state_q     <= HZ_RUN;
            stall_cnt_q <= '0;
        end else if (!pipe_hold) begin
            ex_q        <= nop_insert ? shadow_entry_t'('0) : id_entry;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz_state  = (state_q == HZ_STALL);
    assign stall_cnt = stall_cnt_q;

endmodule
